// File: rtl/regs_wb_arb.sv
// Register-file write-port arbiter (pipeline vs multi-cycle writeback) with a
// per-register pending-write scoreboard for multi-cycle issues.
module regs_wb_arb #(
  parameter int STARVE_MAX = 4,
  parameter int MAX_OUT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mc_issue_valid,
  output logic        mc_issue_ready,
  input  logic [4:0]  mc_issue_rd,
  input  logic        mc_wb_valid,
  output logic        mc_wb_ready,
  input  logic [4:0]  mc_wb_rd,
  input  logic [31:0] mc_wb_data,
  output logic        w_regs_en,
  output logic [4:0]  w_regs_addr,
  output logic [31:0] w_regs_data,
  output logic [31:0] sb_busy,
  output logic [4:0]  mc_outstanding,
  output logic        err
);

  logic [3:0]  r_starve_cnt;
  logic        r_en;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [31:0] r_busy;
  logic [4:0]  r_outs;
  logic        r_err;

  logic        w_starved;
  logic        w_mc_win;
  logic        w_pipe_xfer;
  logic        w_mc_xfer;
  logic        w_issue_xfer;
  logic [31:0] w_clr_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_nxt;
  logic [4:0]  w_outs_nxt;
  logic        w_err_set;

  // mc takes the port when alone, or when it has waited STARVE_MAX cycles behind pipe
  assign w_starved    = (r_starve_cnt >= 4'(STARVE_MAX));
  assign w_mc_win     = mc_wb_valid && (!pipe_valid || w_starved);
  assign w_pipe_xfer  = !rst && pipe_valid && !w_mc_win;
  assign w_mc_xfer    = !rst && w_mc_win;
  assign pipe_ready   = w_pipe_xfer;
  assign mc_wb_ready  = w_mc_xfer;

  assign mc_issue_ready = !rst && ((mc_issue_rd == 5'd0) || !r_busy[mc_issue_rd])
                          && (r_outs < 5'(MAX_OUT));
  assign w_issue_xfer   = mc_issue_valid && mc_issue_ready;

  // Set beats clear on a same-register collision; x0 never reads as busy
  assign w_clr_mask = w_mc_xfer    ? (32'd1 << mc_wb_rd)    : 32'd0;
  assign w_set_mask = w_issue_xfer ? (32'd1 << mc_issue_rd) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;

  assign w_err_set = (w_mc_xfer && (mc_wb_rd != 5'd0) && !r_busy[mc_wb_rd])
                   || (w_mc_xfer && (r_outs == 5'd0))
                   || (w_pipe_xfer && r_busy[pipe_rd]);

  // Outstanding-count update; a writeback with nothing outstanding cannot underflow
  always_comb begin
    w_outs_nxt = r_outs;
    case ({w_issue_xfer, w_mc_xfer && (r_outs != 5'd0)})
      2'b10:   w_outs_nxt = r_outs + 5'd1;
      2'b01:   w_outs_nxt = r_outs - 5'd1;
      default: w_outs_nxt = r_outs;
    endcase
  end

  // Arbitration fairness counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (mc_wb_valid && !w_mc_win) begin
      r_starve_cnt <= (r_starve_cnt == 4'd15) ? 4'd15 : r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

  // Registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_addr <= 5'd0;
      r_data <= 32'd0;
    end else if (w_mc_xfer) begin
      r_en   <= (mc_wb_rd != 5'd0);
      r_addr <= mc_wb_rd;
      r_data <= mc_wb_data;
    end else if (w_pipe_xfer) begin
      r_en   <= (pipe_rd != 5'd0);
      r_addr <= pipe_rd;
      r_data <= pipe_data;
    end else begin
      r_en   <= 1'b0;
    end
  end

  // Scoreboard state and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
      r_outs <= 5'd0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_outs <= w_outs_nxt;
      r_err  <= r_err | w_err_set;
    end
  end

  assign w_regs_en      = r_en;
  assign w_regs_addr    = r_addr;
  assign w_regs_data    = r_data;
  assign sb_busy        = r_busy;
  assign mc_outstanding = r_outs;
  assign err            = r_err;

endmodule

// File: tb/tb_regs_wb_arb.sv
// Directed self-checking bench for regs_wb_arb: expected writes are queued when a
// transfer is driven and compared when the write port presents them.
module tb_regs_wb_arb;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, pipe_ready;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_issue_valid, mc_issue_ready;
  logic [4:0]  mc_issue_rd;
  logic        mc_wb_valid, mc_wb_ready;
  logic [4:0]  mc_wb_rd;
  logic [31:0] mc_wb_data;
  logic        w_regs_en;
  logic [4:0]  w_regs_addr;
  logic [31:0] w_regs_data;
  logic [31:0] sb_busy;
  logic [4:0]  mc_outstanding;
  logic        err;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  regs_wb_arb #(.STARVE_MAX(4), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_issue_valid(mc_issue_valid), .mc_issue_ready(mc_issue_ready), .mc_issue_rd(mc_issue_rd),
    .mc_wb_valid(mc_wb_valid), .mc_wb_ready(mc_wb_ready), .mc_wb_rd(mc_wb_rd), .mc_wb_data(mc_wb_data),
    .w_regs_en(w_regs_en), .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data),
    .sb_busy(sb_busy), .mc_outstanding(mc_outstanding), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: check readies mid-cycle, queue the expected write, then check the port.
  task automatic tick(input logic ep, input logic em, input logic ei);
    wr_t w;
    wr_t got;
    @(negedge clk);
    chk("pipe_ready", 32'(pipe_ready), 32'(ep));
    chk("mc_wb_ready", 32'(mc_wb_ready), 32'(em));
    chk("mc_issue_ready", 32'(mc_issue_ready), 32'(ei));
    w = '0;
    if (em) begin
      w.en = (mc_wb_rd != 5'd0); w.addr = mc_wb_rd; w.data = mc_wb_data;
    end else if (ep) begin
      w.en = (pipe_rd != 5'd0); w.addr = pipe_rd; w.data = pipe_data;
    end
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("w_regs_en", 32'(w_regs_en), 32'(got.en));
      if (got.en) begin
        chk("w_regs_addr", 32'(w_regs_addr), 32'(got.addr));
        chk("w_regs_data", w_regs_data, got.data);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h1111_1111;
    mc_issue_valid = 1'b1; mc_issue_rd = 5'd6;
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd8; mc_wb_data = 32'h2222_2222;

    // Reset with all requesters valid
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_busy", sb_busy, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_outs", 32'(mc_outstanding), 32'd0);
    rst = 1'b0;
    pipe_valid = 1'b0; mc_issue_valid = 1'b0; mc_issue_rd = 5'd0; mc_wb_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b1);

    // Single pipe write, one-cycle latency
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick(1'b1, 1'b0, 1'b1);
    pipe_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b1);

    // Scoreboard fill
    mc_issue_valid = 1'b1; mc_issue_rd = 5'd9;
    tick(1'b0, 1'b0, 1'b1);
    chk("busy9", 32'(sb_busy[9]), 32'd1);
    chk("outs1", 32'(mc_outstanding), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    mc_issue_rd = 5'd7;  tick(1'b0, 1'b0, 1'b1);
    mc_issue_rd = 5'd10; tick(1'b0, 1'b0, 1'b1);
    mc_issue_rd = 5'd11; tick(1'b0, 1'b0, 1'b1);
    mc_issue_rd = 5'd13; tick(1'b0, 1'b0, 1'b0);
    chk("outs4", 32'(mc_outstanding), 32'd4);
    chk("busy_set", sb_busy, 32'h0000_0E80);
    mc_issue_valid = 1'b0; mc_issue_rd = 5'd0;

    // Starvation: pipe keeps winning for STARVE_MAX cycles, then mc is forced through
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hA5A5_0003;
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd7; mc_wb_data = 32'hC0DE_0007;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk("busy7_clr", 32'(sb_busy[7]), 32'd0);
    chk("outs3", 32'(mc_outstanding), 32'd3);
    mc_wb_valid = 1'b0;
    tick(1'b1, 1'b0, 1'b1);
    chk("no_err", 32'(err), 32'd0);

    // x0 handling
    pipe_rd = 5'd0; pipe_data = 32'hFFFF_FFFF;
    tick(1'b1, 1'b0, 1'b1);
    pipe_valid = 1'b0;
    mc_issue_valid = 1'b1; mc_issue_rd = 5'd0;
    tick(1'b0, 1'b0, 1'b1);
    mc_issue_valid = 1'b0;
    chk("x0_outs_up", 32'(mc_outstanding), 32'd4);
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd0; mc_wb_data = 32'h0BAD_0000;
    tick(1'b0, 1'b1, 1'b0);
    chk("x0_outs_dn", 32'(mc_outstanding), 32'd3);
    chk("x0_err", 32'(err), 32'd0);

    // Writeback to a non-busy register: error, but the write still lands
    mc_wb_rd = 5'd12; mc_wb_data = 32'h1234_5678;
    tick(1'b0, 1'b1, 1'b1);
    mc_wb_valid = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      chk("err_sticky", 32'(err), 32'd1);
    end
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    chk("busy_clr", sb_busy, 32'd0);
    chk("outs_clr", 32'(mc_outstanding), 32'd0);

    // WAW: pipe writes a register reserved by an mc issue
    mc_issue_valid = 1'b1; mc_issue_rd = 5'd9;
    tick(1'b0, 1'b0, 1'b1);
    mc_issue_valid = 1'b0; mc_issue_rd = 5'd0;
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h0000_0909;
    tick(1'b1, 1'b0, 1'b1);
    pipe_valid = 1'b0;
    chk("waw_err", 32'(err), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
